// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg                                                             |
// | Definitions shared by the MIPS core and its boot-time program        |
// | loader: instruction-memory geometry and the loader state encoding.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mips_pkg;

  // Instruction-memory geometry, shared with the core's instruction memory.
  localparam int INST_DEPTH     = 1024;
  localparam int ADDR_WIDTH     = 10;

  // Instructions are assembled from this many stream bytes.
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_packer                                                          |
// | Packs a byte stream into big-endian 32-bit words. The first byte of  |
// | a word lands in [31:24], the fourth in [7:0].                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   push       in   a byte is accepted this cycle
//   flush      in   the pushed byte ends the word early (final byte)
//   byte_in    in   byte being pushed
//   word_next  out  packed word including byte_in at the current index;
//                   bytes not yet received read as zero
//   word_full  out  the current index is the last byte of a word
module word_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        flush,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] packer;
  logic [1:0]  byte_idx;

  // The packer is cleared after every word, so lanes not yet written are
  // already zero; that is what provides the zero fill on an early flush.
  always_comb begin
    word_next = packer;
    case (byte_idx)
      2'd0:    word_next[31:24] = byte_in;
      2'd1:    word_next[23:16] = byte_in;
      2'd2:    word_next[15:8]  = byte_in;
      default: word_next[7:0]   = byte_in;
    endcase
  end

  assign word_full = (byte_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      packer   <= '0;
      byte_idx <= '0;
    end else if (push) begin
      if (flush || word_full) begin
        packer   <= '0;
        byte_idx <= '0;
      end else begin
        packer   <= word_next;
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_loader                                                          |
// | Boot-time program loader: accepts a byte stream over valid/ready,    |
// | packs big-endian words and writes them to instruction memory from    |
// | address 0 while holding the core in reset.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   in_valid    in   byte present on in_byte
//   in_byte     in   stream byte
//   in_last     in   final byte of the program (qualified by in_valid)
//   in_ready    out  loader accepts a byte this cycle
//   mem_we      out  single-cycle instruction-memory write strobe
//   mem_addr    out  word address of the write
//   mem_wdata   out  word to write
//   core_rst    out  core reset, released once the load is done
//   done        out  load complete, sticky until rst
//   err         out  overflow or partial final word, sticky until rst
//   word_count  out  number of words written (saturates at INST_DEPTH)
module inst_loader #(
  parameter int INST_DEPTH = mips_pkg::INST_DEPTH,
  parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(INST_DEPTH);

  mips_pkg::loader_state_t state, state_next;

  logic        accept;
  logic        word_end;
  logic        overflow;
  logic        last_word;
  logic        word_full;
  logic [31:0] word_next;
  logic        ready_d;
  logic        we_d;
  logic        done_d;
  logic        core_rst_d;

  assign accept   = in_valid && in_ready;
  // A word closes on its fourth byte or on any byte flagged as last.
  assign word_end = accept && (word_full || in_last);
  assign overflow = (word_count == DEPTH_CNT);

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .flush     (in_last),
    .byte_in   (in_byte),
    .word_next (word_next),
    .word_full (word_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= mips_pkg::LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. An overflowing word skips WRITE entirely so the
  // source keeps streaming at full rate and, on the last byte, the core
  // is released one cycle after that byte.
  always_comb begin
    state_next = state;
    case (state)
      mips_pkg::LOAD: begin
        if (word_end) begin
          if (overflow) begin
            state_next = in_last ? mips_pkg::DONE : mips_pkg::LOAD;
          end else begin
            state_next = mips_pkg::WRITE;
          end
        end
      end
      mips_pkg::WRITE: state_next = last_word ? mips_pkg::DONE : mips_pkg::LOAD;
      mips_pkg::DONE:  state_next = mips_pkg::DONE;
      default:         state_next = mips_pkg::LOAD;
    endcase
  end

  // Output logic: decoded from the next state so the flops below present
  // each state's outputs during the cycle that state is resident.
  always_comb begin
    ready_d    = (state_next == mips_pkg::LOAD);
    we_d       = (state_next == mips_pkg::WRITE);
    done_d     = (state_next == mips_pkg::DONE);
    core_rst_d = (state_next != mips_pkg::DONE);
  end

  // Registered outputs, word counter and memory-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      last_word  <= 1'b0;
    end else begin
      in_ready <= ready_d;
      mem_we   <= we_d;
      done     <= done_d;
      core_rst <= core_rst_d;

      if (word_end && !overflow) begin
        mem_addr  <= word_count[ADDR_WIDTH-1:0];
        mem_wdata <= word_next;
        last_word <= in_last;
      end

      // Partial final word (last flag before the fourth byte) or overflow.
      if (word_end && (overflow || (in_last && !word_full))) begin
        err <= 1'b1;
      end

      // WRITE is never entered at capacity; the guard keeps saturation
      // explicit.
      if ((state == mips_pkg::WRITE) && !overflow) begin
        word_count <= word_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_loader                                                       |
// | Self-checking bench for inst_loader with a small instruction memory  |
// | so that overflow is reachable with short streams.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_inst_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  inst_loader #(
    .INST_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  int            acc_cyc_q[$];
  logic [7:0]    acc_byte_q[$];
  int            rel_q[$];       // cycles with core_rst low
  int            rdy_low_q[$];   // cycles with in_ready low outside WRITE/DONE

  // Observe the bus mid-cycle; a byte seen with valid&ready here is taken
  // on the following rising edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        acc_cyc_q.push_back(cyc);
        acc_byte_q.push_back(in_byte);
      end
      if (!core_rst) rel_q.push_back(cyc);
      if (!in_ready && !mem_we && !done) rdy_low_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: big-endian word w of a program, zero-filled past its end.
  function automatic logic [31:0] pack(input logic [7:0] b[$], input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = 4 * w + k;
      r = {r[23:0], (idx < b.size()) ? b[idx] : 8'h00};
    end
    return r;
  endfunction

  // Presents b as a stream. When the loader is not ready, junk with
  // in_valid high is driven to show it is ignored. gap = idle cycles after
  // each accepted byte; trail = junk cycles after the stream.
  task automatic drive_stream(input logic [7:0] b[$], input bit with_last,
                              input int gap, input int trail);
    int i = 0;
    int g = 0;
    int guard = 0;
    while (i < b.size() && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      if (g > 0) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        in_last  = 1'($urandom);
        g--;
      end else if (in_ready) begin
        in_valid = 1'b1;
        in_byte  = b[i];
        in_last  = with_last && (i == b.size() - 1);
        i++;
        g = gap;
      end else begin
        in_valid = 1'b1;
        in_byte  = 8'($urandom);
        in_last  = 1'($urandom);
      end
    end
    checks++;
    if (guard >= 5000) begin
      errors++;
      $display("FAIL stream_timeout: sent %0d of %0d bytes", i, b.size());
    end
    @(posedge clk); #1;
    repeat (trail) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mon_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err, word_count} !==
        {1'b0, 1'b0, {AW{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, {(AW+1){1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b wc=%0d expected 0 0 0 0 1 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err, word_count);
    end
    rst = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    acc_cyc_q.delete(); acc_byte_q.delete(); rel_q.delete(); rdy_low_q.delete();
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] b[$];
    test_reset();
    b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    drive_stream(b, 1'b1, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wr_data_q.size() != 2) begin
      errors++;
      $display("FAIL basic_nwrites: got %0d expected 2", wr_data_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 2'd0 || wr_data_q[0] !== 32'h20080005) begin
        errors++;
        $display("FAIL basic_word0: got %h@%0d expected 20080005@0", wr_data_q[0], wr_addr_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 2'd1 || wr_data_q[1] !== 32'h00000000) begin
        errors++;
        $display("FAIL basic_word1: got %h@%0d expected 00000000@1", wr_data_q[1], wr_addr_q[1]);
      end
      checks++;
      if (wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
        errors++;
        $display("FAIL basic_throughput: got %0d cycles per word expected 5", wr_cyc_q[1] - wr_cyc_q[0]);
      end
      checks++;
      if (rel_q.size() == 0 || rel_q[0] != wr_cyc_q[1] + 1) begin
        errors++;
        $display("FAIL basic_core_rst: got release cycle %0d expected %0d",
                 (rel_q.size() == 0) ? -1 : rel_q[0], wr_cyc_q[1] + 1);
      end
    end
    checks++;
    if ({word_count, done, err, core_rst} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_status: got wc=%0d done=%b err=%b crst=%b expected 2 1 0 0",
               word_count, done, err, core_rst);
    end
  endtask

  task automatic test_partial();
    logic [7:0] b[$];
    test_reset();
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    drive_stream(b, 1'b1, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wr_data_q.size() != 2) begin
      errors++;
      $display("FAIL partial_nwrites: got %0d expected 2", wr_data_q.size());
    end else begin
      checks++;
      if (wr_data_q[0] !== 32'hAABBCCDD || wr_data_q[1] !== 32'h11000000 || wr_addr_q[1] !== 2'd1) begin
        errors++;
        $display("FAIL partial_words: got %h %h@%0d expected AABBCCDD 11000000@1",
                 wr_data_q[0], wr_data_q[1], wr_addr_q[1]);
      end
    end
    checks++;
    if ({word_count, done, err} !== {3'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL partial_status: got wc=%0d done=%b err=%b expected 2 1 1", word_count, done, err);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] b[$];
    test_reset();
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive_stream(b, 1'b1, 2, 0);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'h01020304 || wr_addr_q[0] !== 2'd0) begin
      errors++;
      $display("FAIL gapped_write: got %0d writes first %h expected 1 write 01020304@0",
               wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx);
    end
    checks++;
    if (rdy_low_q.size() != 0) begin
      errors++;
      $display("FAIL gapped_ready: got %0d cycles ready low outside WRITE expected 0", rdy_low_q.size());
    end
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++;
      $display("FAIL gapped_status: got done=%b err=%b expected 1 0", done, err);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b[$];
    test_reset();
    for (int k = 0; k < 20; k++) b.push_back(8'($urandom));
    drive_stream(b, 1'b1, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wr_data_q.size() != DEPTH) begin
      errors++;
      $display("FAIL ovf_nwrites: got %0d expected %0d", wr_data_q.size(), DEPTH);
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        checks++;
        if (wr_addr_q[w] !== AW'(w) || wr_data_q[w] !== pack(b, w)) begin
          errors++;
          $display("FAIL ovf_word%0d: got %h@%0d expected %h@%0d", w, wr_data_q[w], wr_addr_q[w], pack(b, w), w);
        end
      end
    end
    checks++;
    if (acc_cyc_q.size() != 20 || rel_q.size() == 0 || rel_q[0] != acc_cyc_q[19] + 1) begin
      errors++;
      $display("FAIL ovf_core_rst: got %0d accepts release %0d expected 20 accepts release after last byte",
               acc_cyc_q.size(), (rel_q.size() == 0) ? -1 : rel_q[0]);
    end
    checks++;
    if ({word_count, done, err} !== {3'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_status: got wc=%0d done=%b err=%b expected 4 1 1", word_count, done, err);
    end
  endtask

  task automatic test_rst_midload();
    logic [7:0] b[$];
    test_reset();
    for (int k = 0; k < 6; k++) b.push_back(8'($urandom));
    drive_stream(b, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== pack(b, 0)) begin
      errors++;
      $display("FAIL midload_pre: got %0d writes expected 1 of %h", wr_data_q.size(), pack(b, 0));
    end
    test_reset();
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    drive_stream(b, 1'b1, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'hDEADBEEF || wr_addr_q[0] !== 2'd0) begin
      errors++;
      $display("FAIL midload_write: got %0d writes first %h expected 1 write DEADBEEF@0",
               wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx);
    end
    checks++;
    if ({word_count, done, err} !== {3'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midload_status: got wc=%0d done=%b err=%b expected 1 1 0", word_count, done, err);
    end
  endtask

  task automatic test_busy_valid();
    logic [7:0] b[$];
    test_reset();
    for (int k = 0; k < 12; k++) b.push_back(8'($urandom));
    drive_stream(b, 1'b1, 0, 10);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (acc_byte_q.size() != 12 || acc_byte_q != b) begin
      errors++;
      $display("FAIL busy_absorbed: got %0d bytes accepted expected exactly the 12 stream bytes", acc_byte_q.size());
    end
    checks++;
    if (wr_data_q.size() != 3 || wr_data_q[0] !== pack(b, 0) || wr_data_q[1] !== pack(b, 1) ||
        wr_data_q[2] !== pack(b, 2)) begin
      errors++;
      $display("FAIL busy_words: got %0d writes expected %h %h %h", wr_data_q.size(),
               pack(b, 0), pack(b, 1), pack(b, 2));
    end
    checks++;
    if ({word_count, done, err} !== {3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL busy_status: got wc=%0d done=%b err=%b expected 3 1 0", word_count, done, err);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [7:0] b[$];
      int n, nwords, nexp, gap, lastw, exp_rel;
      bit exp_err;
      b.delete();
      n   = $urandom_range(1, 22);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) b.push_back(8'($urandom));
      test_reset();
      drive_stream(b, 1'b1, gap, $urandom_range(0, 4));
      repeat (8) @(posedge clk);
      #1;
      nwords  = (n + 3) / 4;
      nexp    = (nwords < DEPTH) ? nwords : DEPTH;
      exp_err = ((n % 4) != 0) || (nwords > DEPTH);
      checks++;
      if (acc_byte_q.size() != n || acc_byte_q != b) begin
        errors++;
        $display("FAIL rnd%0d_accepts: got %0d bytes expected %0d", it, acc_byte_q.size(), n);
      end else begin
        checks++;
        if (wr_data_q.size() != nexp) begin
          errors++;
          $display("FAIL rnd%0d_nwrites: got %0d expected %0d (n=%0d)", it, wr_data_q.size(), nexp, n);
        end else begin
          for (int w = 0; w < nexp; w++) begin
            lastw = (4 * w + 3 < n) ? 4 * w + 3 : n - 1;
            checks++;
            if (wr_addr_q[w] !== AW'(w) || wr_data_q[w] !== pack(b, w) ||
                wr_cyc_q[w] != acc_cyc_q[lastw] + 1) begin
              errors++;
              $display("FAIL rnd%0d_word%0d: got %h@%0d cyc %0d expected %h@%0d cyc %0d", it, w,
                       wr_data_q[w], wr_addr_q[w], wr_cyc_q[w], pack(b, w), w, acc_cyc_q[lastw] + 1);
            end
          end
        end
        exp_rel = (nwords <= DEPTH) ? acc_cyc_q[n-1] + 2 : acc_cyc_q[n-1] + 1;
        checks++;
        if (rel_q.size() == 0 || rel_q[0] != exp_rel) begin
          errors++;
          $display("FAIL rnd%0d_core_rst: got release %0d expected %0d", it,
                   (rel_q.size() == 0) ? -1 : rel_q[0], exp_rel);
        end
      end
      checks++;
      if ({word_count, done, err} !== {3'(nexp), 1'b1, exp_err}) begin
        errors++;
        $display("FAIL rnd%0d_status: got wc=%0d done=%b err=%b expected %0d 1 %b", it,
                 word_count, done, err, nexp, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_gapped();
    test_overflow();
    test_rst_midload();
    test_busy_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
